// File: rtl/chip8_timers.sv
// chip8_timers
//   Delay/sound timer unit for the CHIP-8 core. Decrements DT and ST once per
//   rising edge of the 60 Hz tick, lets the CPU load them (Fx15/Fx18) and read
//   DT back (Fx07), and drives a square-wave buzzer while ST is non-zero.
//
// Ports
//   clk_in      in   system clock, rising-edge active
//   reset       in   synchronous, active-low
//   tick_60hz   in   60 Hz tick from the divider (level; rising edge counts)
//   dt_we       in   load DT from wdata
//   st_we       in   load ST from wdata
//   wdata       in   [7:0] load value
//   dt_value    out  [7:0] current DT (registered)
//   st_value    out  [7:0] current ST (registered)
//   sound_on    out  ST non-zero
//   tone_out    out  buzzer square wave (registered)
//   dt_expired  out  one-cycle pulse when DT reaches 0 by decrement
//
// Tone FSM
//   state | meaning
//   IDLE  | ST is zero; counter and tone held at 0
//   RUN   | ST non-zero; counter runs, tone toggles every HALF cycles

module chip8_timers #(
  parameter int CLK_HZ  = 50_000_000,
  parameter int TONE_HZ = 440
) (
  input  logic       clk_in,
  input  logic       reset,
  input  logic       tick_60hz,
  input  logic       dt_we,
  input  logic       st_we,
  input  logic [7:0] wdata,
  output logic [7:0] dt_value,
  output logic [7:0] st_value,
  output logic       sound_on,
  output logic       tone_out,
  output logic       dt_expired
);

  localparam int HALF = CLK_HZ / (2 * TONE_HZ);
  localparam int CW   = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [CW-1:0] CNT_TOP = CW'(HALF - 1);

  typedef enum logic {IDLE, RUN} state_t;

  logic          tick_q;
  logic [7:0]    dt_q, dt_d;
  logic [7:0]    st_q, st_d;
  logic          exp_q, exp_d;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          tone_q, tone_d;
  logic          tick_ev;

  // A tick held high for several cycles counts only once.
  assign tick_ev = tick_60hz & ~tick_q;

  // Timers: write beats a coincident tick; decrement saturates at zero.
  always_comb begin
    dt_d  = dt_q;
    st_d  = st_q;
    exp_d = 1'b0;
    if (dt_we) begin
      dt_d = wdata;
    end else if (tick_ev && dt_q != 8'd0) begin
      dt_d = dt_q - 8'd1;
    end
    if (st_we) begin
      st_d = wdata;
    end else if (tick_ev && st_q != 8'd0) begin
      st_d = st_q - 8'd1;
    end
    if (tick_ev && !dt_we && dt_q == 8'd1) begin
      exp_d = 1'b1;
    end
  end

  // Tone generator. An ST reload while running leaves the phase untouched.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tone_d  = tone_q;
    case (state_q)
      IDLE: begin
        cnt_d  = '0;
        tone_d = 1'b0;
        if (st_q != 8'd0) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (st_q == 8'd0) begin
          state_d = IDLE;
          cnt_d   = '0;
          tone_d  = 1'b0;
        end else if (cnt_q == CNT_TOP) begin
          cnt_d  = '0;
          tone_d = ~tone_q;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        tone_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!reset) begin
      tick_q  <= 1'b0;
      dt_q    <= 8'd0;
      st_q    <= 8'd0;
      exp_q   <= 1'b0;
      state_q <= IDLE;
      cnt_q   <= '0;
      tone_q  <= 1'b0;
    end else begin
      tick_q  <= tick_60hz;
      dt_q    <= dt_d;
      st_q    <= st_d;
      exp_q   <= exp_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tone_q  <= tone_d;
    end
  end

  assign dt_value   = dt_q;
  assign st_value   = st_q;
  assign sound_on   = (st_q != 8'd0);
  assign tone_out   = tone_q;
  assign dt_expired = exp_q;

endmodule

// File: doc/chip8_timers.md
# chip8_timers

Delay/sound timer unit for the CHIP-8 core. Consumes the one-cycle 60 Hz tick produced by the clock divider stage and decrements the two 8-bit CHIP-8 timers (DT, ST) on each tick. Provides CPU load and readback for Fx15/Fx18/Fx07. Drives a square-wave buzzer output while ST is non-zero.

## Interface
- CLK_HZ, 50_000_000, frequency of clk_in in Hz
- TONE_HZ, 440, buzzer square-wave frequency in Hz
- HALF, CLK_HZ/(2*TONE_HZ) (= 56818), derived localparam; counter width $clog2(HALF)

- clk_in  in  1  system clock; all state updates on its rising edge
- reset  in  1  synchronous, active-low (0 = reset)
- tick_60hz  in  1  60 Hz tick from the divider, nominally a one-cycle pulse
- dt_we  in  1  load DT from wdata (Fx15)
- st_we  in  1  load ST from wdata (Fx18)
- wdata  in  8  load value
- dt_value  out  8  current DT, registered (Fx07 read)
- st_value  out  8  current ST, registered
- sound_on  out  1  high when st_value != 0 (combinational from register)
- tone_out  out  1  buzzer square wave, registered
- dt_expired  out  1  one-cycle pulse when DT reaches 0 by decrement

## Operation
- Tick detection: register tick_q <= tick_60hz; tick_ev = tick_60hz & ~tick_q. A tick held high for N cycles counts once.
- Per timer, priority per cycle: reset > write > tick_ev decrement > hold.
  - write: timer <= wdata; a coincident tick_ev is discarded for that timer (no decrement of the new value).
  - tick_ev with timer > 0: timer <= timer - 1.
  - tick_ev with timer == 0: timer stays 0 (saturating, never wraps to 255).
- dt_we and st_we may both be asserted in one cycle: both timers load wdata.
- dt_expired <= 1 exactly when DT is 1, tick_ev = 1 and dt_we = 0; otherwise 0. Writing 0 never pulses it.
- Tone generator, states IDLE / RUN:
  - IDLE: tone_cnt = 0, tone_out = 0. Move to RUN on the cycle after st_value becomes non-zero.
  - RUN: tone_cnt increments each cycle. At tone_cnt == HALF-1, tone_cnt <= 0 and tone_out toggles. Return to IDLE (tone_cnt <= 0, tone_out <= 0) on the cycle after st_value becomes 0.
  - An ST reload while in RUN does not reset tone phase.

## Timing
- Reset: when reset = 0 at a rising edge, next state is dt_value = 0, st_value = 0, tick_q = 0, dt_expired = 0, tone_out = 0, tone_cnt = 0, FSM = IDLE. It therefore follows that sound_on = 0. Reset mid-count or mid-tone aborts immediately. tick_60hz and writes are ignored while reset = 0.
- Write latency: value visible on dt_value/st_value 1 cycle after the we edge.
- Tick latency: decremented value visible 1 cycle after the first cycle tick_60hz is high. dt_expired is high during that same cycle.
- sound_on follows st_value with 0 added latency. tone_out is first high HALF cycles after entering RUN.
- Tone period = 2*HALF clk_in cycles (50 MHz: 113636 cycles, about 440.0 Hz).
- Throughput: writes accepted every cycle; there is no busy or ready signal.

## Test plan
- Reset: hold reset = 0 with tick_60hz, dt_we and st_we toggling -> all outputs 0. Release reset -> all outputs still 0 until the first write.
- Countdown: dt_we with wdata = 3, then 4 ticks one cycle wide, 10 cycles apart -> dt_value is 2, 1, 0, 0. dt_expired pulses once, in the cycle dt_value becomes 0. No wrap to 255.
- Collision: dt_we with wdata = 5 in the same cycle as a tick rising edge -> dt_value = 5, not 4. Next tick -> 4. Tick held high 20 cycles -> exactly one decrement.
- Dual write and zero write: dt_we = st_we = 1 with wdata = 0x2A -> both values 0x2A. dt_we with wdata = 0 while DT = 7 -> DT = 0 and no dt_expired pulse.
- Tone: CLK_HZ = 1000, TONE_HZ = 100 (HALF = 5). st_we with wdata = 2 -> sound_on high. tone_out toggles every 5 cycles. After 2 ticks, sound_on is 0 and tone_out is 0 on the following cycle.
- Reset mid-tone: assert reset = 0 while tone_out = 1 and ST = 9 -> next cycle st_value = 0, tone_out = 0, FSM = IDLE.
